mux_sel_reg: RTL and testbench

Parametrised N-channel, W-bit registered selector for the BIP datapath. It is the pipelined successor of the 2:1 operand multiplexer. It picks one of N source channels, either by an explicit select or by round-robin scan over channels presenting valid data. The chosen word goes into a one-stage output register with valid/ready handshaking on both sides, so sources and the consumer stall cleanly.

---
 rtl/mux_sel_reg.sv | 125 ++++++++++++
 tb/tb_mux_sel_reg.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_reg.sv
// rtl/mux_sel_reg.sv - N-channel W-bit registered selector with fixed or round-robin choice
//
// Picks one of N source channels and holds the chosen word in a single output
// register with valid/ready handshaking on both sides.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   entradas   channel data, channel i at bits [i*W +: W]
//   valid_in   per-channel data valid
//   ready_in   per-channel accept, one-hot or zero
//   sel        channel index used when modo = 0
//   modo       0 = fixed select, 1 = round-robin over valid channels
//   salida     registered selected data
//   valid_out  salida holds a word not yet consumed
//   ready_out  consumer accepts salida
//   canal      index of the channel that supplied salida
module mux_sel_reg #(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*W-1:0]       entradas,
    input  logic [N-1:0]         valid_in,
    output logic [N-1:0]         ready_in,
    input  logic [$clog2(N)-1:0] sel,
    input  logic                 modo,
    output logic [W-1:0]         salida,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [$clog2(N)-1:0] canal
);

    localparam int SW = $clog2(N);
    // Pointer resets to the last channel so the first round-robin search
    // begins at channel 0.
    localparam logic [SW-1:0] PTR_RST = SW'(N - 1);

    logic [W-1:0]  salida_q, salida_d;
    logic [SW-1:0] canal_q,  canal_d;
    logic          valid_q,  valid_d;
    logic [SW-1:0] ptr_q,    ptr_d;

    logic          load_ok;
    logic          cand_vld;
    logic [SW-1:0] cand;
    logic          xfer;

    // Candidate selection. Fixed mode compares sel against every legal index,
    // so an out-of-range sel simply never matches. Round-robin walks
    // ptr+1 .. ptr+N modulo N, visiting ptr itself last.
    always_comb begin
        int            idx;
        logic [SW-1:0] idx_s;
        cand_vld = 1'b0;
        cand     = '0;
        idx      = 0;
        idx_s    = '0;
        if (!modo) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && valid_in[i]) begin
                    cand_vld = 1'b1;
                    cand     = SW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                idx_s = SW'(idx);
                if (!cand_vld && valid_in[idx_s]) begin
                    cand_vld = 1'b1;
                    cand     = idx_s;
                end
            end
        end
    end

    // Stage can take a word when empty or when its word leaves this cycle.
    // rst_n gating keeps ready_in low while reset is held.
    always_comb begin
        load_ok  = !valid_q || ready_out;
        xfer     = cand_vld && load_ok && rst_n;
        ready_in = xfer ? (N'(1) << cand) : '0;
    end

    always_comb begin
        salida_d = salida_q;
        canal_d  = canal_q;
        valid_d  = valid_q;
        ptr_d    = ptr_q;
        if (xfer) begin
            salida_d = entradas[int'(cand)*W +: W];
            canal_d  = cand;
            valid_d  = 1'b1;
            if (modo) begin
                ptr_d = cand;
            end
        end else if (valid_q && ready_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            salida_q <= '0;
            canal_q  <= '0;
            valid_q  <= 1'b0;
            ptr_q    <= PTR_RST;
        end else begin
            salida_q <= salida_d;
            canal_q  <= canal_d;
            valid_q  <= valid_d;
            ptr_q    <= ptr_d;
        end
    end

    assign salida    = salida_q;
    assign canal     = canal_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_mux_sel_reg.sv
// tb/tb_mux_sel_reg.sv - self-checking bench for mux_sel_reg (N=4 and N=3 instances)
module tb_mux_sel_reg;

    logic clk;
    logic rst_n;

    // N=4, W=16 instance
    logic [63:0] ent4;
    logic [3:0]  vin4;
    logic [3:0]  rdy4;
    logic [1:0]  sel4;
    logic        modo4;
    logic [15:0] sal4;
    logic        vout4;
    logic        rout4;
    logic [1:0]  can4;

    // N=3, W=16 instance
    logic [47:0] ent3;
    logic [2:0]  vin3;
    logic [2:0]  rdy3;
    logic [1:0]  sel3;
    logic        modo3;
    logic [15:0] sal3;
    logic        vout3;
    logic        rout3;
    logic [1:0]  can3;

    int checks = 0;
    int errors = 0;

    // Reference state for the N=4 instance
    logic [15:0] m_sal;
    int          m_can;
    logic        m_val;
    int          m_ptr;

    mux_sel_reg #(.W(16), .N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .entradas(ent4), .valid_in(vin4),
        .ready_in(rdy4), .sel(sel4), .modo(modo4), .salida(sal4),
        .valid_out(vout4), .ready_out(rout4), .canal(can4)
    );

    mux_sel_reg #(.W(16), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .entradas(ent3), .valid_in(vin3),
        .ready_in(rdy3), .sel(sel3), .modo(modo3), .salida(sal3),
        .valid_out(vout3), .ready_out(rout3), .canal(can3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel the rules pick this cycle, or -1 for none.
    function automatic int model_grant();
        if (!modo4) begin
            return vin4[sel4] ? int'(sel4) : -1;
        end
        for (int k = 1; k <= 4; k++) begin
            if (vin4[(m_ptr + k) % 4]) begin
                return (m_ptr + k) % 4;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_sal = 16'h0;
        m_can = 0;
        m_val = 1'b0;
        m_ptr = 3;
    endtask

    // One clock cycle on the N=4 instance: check the grant, clock, check outputs.
    task automatic cyc(input string tag);
        int         g;
        logic [3:0] er;
        #1;
        g  = model_grant();
        er = ((!m_val || rout4) && g >= 0) ? 4'(1 << g) : 4'b0000;
        check({tag, ".ready_in"}, 32'(rdy4), 32'(er));
        @(posedge clk);
        #1;
        if (er != 4'b0000) begin
            m_sal = ent4[g*16 +: 16];
            m_can = g;
            m_val = 1'b1;
            if (modo4) m_ptr = g;
        end else if (m_val && rout4) begin
            m_val = 1'b0;
        end
        check({tag, ".salida"},    32'(sal4),  32'(m_sal));
        check({tag, ".canal"},     32'(can4),  32'(m_can));
        check({tag, ".valid_out"}, 32'(vout4), 32'(m_val));
    endtask

    initial begin
        int rr_a[5] = '{0, 1, 2, 3, 0};
        int rr_b[4] = '{1, 3, 1, 3};

        rst_n = 1'b0;
        ent4 = '0; vin4 = '0; sel4 = '0; modo4 = 1'b0; rout4 = 1'b1;
        ent3 = '0; vin3 = '0; sel3 = '0; modo3 = 1'b0; rout3 = 1'b1;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset.salida",    32'(sal4),  32'h0);
        check("reset.valid_out", 32'(vout4), 32'h0);
        check("reset.canal",     32'(can4),  32'h0);
        check("reset.ready_in",  32'(rdy4),  32'h0);
        rst_n = 1'b1;

        // Fixed select
        modo4 = 1'b0; sel4 = 2'd2; ent4[47:32] = 16'hBEEF; vin4 = 4'b0100; rout4 = 1'b1;
        cyc("fix");
        check("fix.salida_beef", 32'(sal4), 32'hBEEF);
        check("fix.canal_2",     32'(can4), 32'd2);
        vin4 = 4'b0011;
        cyc("fix_none");
        check("fix_none.valid_out", 32'(vout4), 32'h0);

        // Round-robin fairness
        modo4 = 1'b1; vin4 = 4'b1111;
        ent4 = 64'h4444_3333_2222_1111;
        for (int j = 0; j < 5; j++) begin
            cyc("rr_all");
            check("rr_all.seq", 32'(can4), 32'(rr_a[j]));
        end
        vin4 = 4'b1010;
        for (int j = 0; j < 4; j++) begin
            cyc("rr_odd");
            check("rr_odd.seq", 32'(can4), 32'(rr_b[j]));
        end

        // Back-pressure
        modo4 = 1'b0; sel4 = 2'd0; ent4[15:0] = 16'h1234; vin4 = 4'b0001; rout4 = 1'b1;
        cyc("bp_load");
        rout4 = 1'b0; sel4 = 2'd1; ent4[31:16] = 16'h5678; vin4 = 4'b0010;
        for (int j = 0; j < 3; j++) begin
            cyc("bp_stall");
            check("bp_stall.salida_hold", 32'(sal4), 32'h1234);
        end
        rout4 = 1'b1;
        cyc("bp_release");
        check("bp_release.salida", 32'(sal4),  32'h5678);
        check("bp_release.valid",  32'(vout4), 32'h1);

        // Mode switch: ptr -> 1, fixed traffic, back to round-robin
        modo4 = 1'b1; vin4 = 4'b0010;
        cyc("ms_rr");
        modo4 = 1'b0; sel4 = 2'd3; vin4 = 4'b1000;
        for (int j = 0; j < 4; j++) begin
            ent4[63:48] = 16'(16'hA000 + j);
            cyc("ms_fix");
        end
        modo4 = 1'b1; vin4 = 4'b1111;
        cyc("ms_back");
        check("ms_back.canal_2", 32'(can4), 32'd2);

        // Asynchronous reset in the middle of a stall
        modo4 = 1'b0; sel4 = 2'd0; vin4 = 4'b0001; rout4 = 1'b1;
        cyc("rst_load");
        rout4 = 1'b0;
        cyc("rst_stall");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async.salida",    32'(sal4),  32'h0);
        check("rst_async.valid_out", 32'(vout4), 32'h0);
        check("rst_async.canal",     32'(can4),  32'h0);
        check("rst_async.ready_in",  32'(rdy4),  32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        modo4 = 1'b1; vin4 = 4'b1111; rout4 = 1'b1;
        #1;
        check("rst_first_grant", 32'(rdy4), 32'h1);
        cyc("rst_first");

        // Randomized traffic against the reference model
        for (int j = 0; j < 300; j++) begin
            ent4  = {$urandom, $urandom};
            vin4  = 4'($urandom);
            sel4  = 2'($urandom);
            modo4 = 1'($urandom);
            rout4 = ($urandom % 4) != 0;
            cyc("rnd");
        end

        // N=3: sel=3 never grants
        modo3 = 1'b0; sel3 = 2'd3; rout3 = 1'b1;
        ent3 = 48'hCCCC_BBBB_AAAA;
        for (int v = 0; v < 8; v++) begin
            vin3 = 3'(v);
            #1;
            check("n3_sel3.ready_in", 32'(rdy3), 32'h0);
            @(posedge clk); #1;
            check("n3_sel3.valid_out", 32'(vout3), 32'h0);
        end

        // N=3 round-robin: reset pointer is 2, so channel 2 wraps to itself
        modo3 = 1'b1; vin3 = 3'b100;
        for (int j = 0; j < 2; j++) begin
            #1;
            check("n3_wrap.ready_in", 32'(rdy3), 32'h4);
            @(posedge clk); #1;
            check("n3_wrap.canal",  32'(can3), 32'd2);
            check("n3_wrap.salida", 32'(sal3), 32'hCCCC);
        end
        vin3 = 3'b011;
        #1;
        check("n3_after2.ready_in", 32'(rdy3), 32'h1);
        @(posedge clk); #1;
        check("n3_after2.canal", 32'(can3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
